mc_control_fsm: RTL and testbench

- Parametrised multi-cycle MIPS control unit: main FSM, ALU decoder and branch/PC-enable logic merged into one block.
- Extends the current instruction set (R-type, LW, SW, BEQ) with BNE, ADDI and J.
- Adds a memory ready handshake with wait states, a sticky illegal-opcode trap, and a retired-instruction counter.
- Sits between the IR opcode/funct fields and the datapath muxes/write enables.

---
 rtl/mc_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: main FSM, ALU decoder and PC-enable logic,
// with memory-ready wait states, a sticky illegal-opcode trap and a retire counter.
module mc_control_fsm #(
  parameter int OP_W          = 6,
  parameter int FN_W          = 6,
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [OP_W-1:0]  OPCODE,
  input  logic [FN_W-1:0]  FUNCT,
  input  logic             ZERO,
  input  logic             MEM_RDY,
  output logic             MEM_REQ,
  output logic             MtoRFSel,
  output logic             RFDSel,
  output logic             IDSel,
  output logic             ALUIn1Sel,
  output logic             IRWE,
  output logic             DMWE,
  output logic             PCWE,
  output logic             Branch,
  output logic             RFWE,
  output logic             PCEn,
  output logic [1:0]       PCSel,
  output logic [1:0]       ALUIn2Sel,
  output logic [2:0]       ALUSel,
  output logic             ILLEGAL,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
  localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
  localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
  localparam logic [FN_W-1:0] FN_OR  = FN_W'(6'b100101);
  localparam logic [FN_W-1:0] FN_SLT = FN_W'(6'b101010);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXE   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rdy;
  logic             w_is_bne;
  logic             w_retire;
  logic [1:0]       w_aluop;
  logic             w_irwe;
  logic             w_pcwe;
  logic             w_dmwe;
  logic             w_rfwe;
  logic             w_branch;

  assign w_rdy    = MEM_HANDSHAKE ? MEM_RDY : 1'b1;
  assign w_is_bne = (OPCODE == OP_BNE);
  // Every path back to FETCH ends an instruction; TRAP never returns.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_cnt     <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    MEM_REQ   = 1'b0;
    MtoRFSel  = 1'b0;
    RFDSel    = 1'b0;
    IDSel     = 1'b0;
    ALUIn1Sel = 1'b0;
    w_irwe    = 1'b0;
    w_dmwe    = 1'b0;
    w_pcwe    = 1'b0;
    w_branch  = 1'b0;
    w_rfwe    = 1'b0;
    PCSel     = 2'b00;
    ALUIn2Sel = 2'b00;
    w_aluop   = 2'b00;
    case (r_state)
      S_FETCH: begin
        MEM_REQ   = 1'b1;
        ALUIn2Sel = 2'b01;
        w_irwe    = w_rdy;
        w_pcwe    = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUIn2Sel = 2'b11;
        case (OPCODE)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = S_REXE;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default:        w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUIn1Sel = 1'b1;
        ALUIn2Sel = 2'b10;
        w_next    = (OPCODE == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MEM_REQ = 1'b1;
        IDSel   = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_rfwe   = 1'b1;
        MtoRFSel = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MEM_REQ = 1'b1;
        IDSel   = 1'b1;
        w_dmwe  = w_rdy;
        if (w_rdy) w_next = S_FETCH;
      end
      S_REXE: begin
        ALUIn1Sel = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_RWB;
      end
      S_RWB: begin
        w_rfwe = 1'b1;
        RFDSel = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUIn1Sel = 1'b1;
        w_aluop   = 2'b01;
        PCSel     = 2'b01;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUIn1Sel = 1'b1;
        ALUIn2Sel = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_rfwe = 1'b1;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        PCSel  = 2'b10;
        w_pcwe = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (w_aluop)
      2'b00: ALUSel = 3'b010;
      2'b01: ALUSel = 3'b110;
      default: begin
        case (FUNCT)
          FN_ADD:  ALUSel = 3'b010;
          FN_SUB:  ALUSel = 3'b110;
          FN_AND:  ALUSel = 3'b000;
          FN_OR:   ALUSel = 3'b001;
          FN_SLT:  ALUSel = 3'b111;
          default: ALUSel = 3'b010;
        endcase
      end
    endcase
  end

  // Write enables are held off for as long as reset is asserted, whatever MEM_RDY does.
  assign IRWE      = RST & w_irwe;
  assign PCWE      = RST & w_pcwe;
  assign DMWE      = RST & w_dmwe;
  assign RFWE      = RST & w_rfwe;
  assign PCEn      = RST & (w_pcwe | (w_branch & (ZERO ^ w_is_bne)));
  assign Branch    = w_branch;
  assign ILLEGAL   = r_illegal;
  assign STATE     = r_state;
  assign INSTR_CNT = r_cnt;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-path model plus directed literal checks
// followed by randomized instruction streams with wait states and resets.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [5:0] OPCODE = 6'h00;
  logic [5:0] FUNCT = 6'h20;
  logic ZERO = 1'b0;
  logic MEM_RDY = 1'b1;

  logic MEM_REQ, MtoRFSel, RFDSel, IDSel, ALUIn1Sel, IRWE, DMWE, PCWE, Branch, RFWE, PCEn, ILLEGAL;
  logic [1:0] PCSel, ALUIn2Sel;
  logic [2:0] ALUSel;
  logic [3:0] STATE;
  logic [31:0] INSTR_CNT;

  logic d4_MEM_REQ, d4_MtoRFSel, d4_RFDSel, d4_IDSel, d4_ALUIn1Sel, d4_IRWE, d4_DMWE, d4_PCWE;
  logic d4_Branch, d4_RFWE, d4_PCEn, d4_ILLEGAL;
  logic [1:0] d4_PCSel, d4_ALUIn2Sel;
  logic [2:0] d4_ALUSel;
  logic [3:0] d4_STATE;
  logic [3:0] d4_INSTR_CNT;

  mc_control_fsm dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
    .MEM_REQ(MEM_REQ), .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .IDSel(IDSel), .ALUIn1Sel(ALUIn1Sel),
    .IRWE(IRWE), .DMWE(DMWE), .PCWE(PCWE), .Branch(Branch), .RFWE(RFWE), .PCEn(PCEn),
    .PCSel(PCSel), .ALUIn2Sel(ALUIn2Sel), .ALUSel(ALUSel), .ILLEGAL(ILLEGAL), .STATE(STATE),
    .INSTR_CNT(INSTR_CNT)
  );

  mc_control_fsm #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
    .MEM_REQ(d4_MEM_REQ), .MtoRFSel(d4_MtoRFSel), .RFDSel(d4_RFDSel), .IDSel(d4_IDSel),
    .ALUIn1Sel(d4_ALUIn1Sel), .IRWE(d4_IRWE), .DMWE(d4_DMWE), .PCWE(d4_PCWE), .Branch(d4_Branch),
    .RFWE(d4_RFWE), .PCEn(d4_PCEn), .PCSel(d4_PCSel), .ALUIn2Sel(d4_ALUIn2Sel), .ALUSel(d4_ALUSel),
    .ILLEGAL(d4_ILLEGAL), .STATE(d4_STATE), .INSTR_CNT(d4_INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int ticks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction paths: len in [23:20], state code of step k in nibble k.
  function automatic logic [23:0] path_of(input logic [5:0] op);
    case (op)
      OP_R:           return 24'h407610;
      OP_LW:          return 24'h543210;
      OP_SW:          return 24'h405210;
      OP_BEQ, OP_BNE: return 24'h300810;
      OP_ADDI:        return 24'h40A910;
      OP_J:           return 24'h300B10;
      default:        return 24'h300C10;
    endcase
  endfunction

  function automatic int path_state(input logic [5:0] op, input int idx);
    logic [23:0] w;
    w = path_of(op);
    return int'(w[idx*4 +: 4]);
  endfunction

  function automatic int path_len(input logic [5:0] op);
    logic [23:0] w;
    w = path_of(op);
    return int'(w[23:20]);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [18:0] exp_ctrl(input int st, input logic rdy, input logic zero,
                                           input logic rstn, input logic [5:0] op,
                                           input logic [5:0] fn, input logic ill);
    logic mreq = 0, mtorf = 0, rfd = 0, ids = 0, a1 = 0, irwe = 0, dmwe = 0, pcwe = 0;
    logic br = 0, rfwe = 0, pcen = 0;
    logic [1:0] pcsel = 2'b00, a2 = 2'b00;
    logic [2:0] alu = 3'b010;
    case (st)
      0:  begin mreq = 1; a2 = 2'b01; irwe = rdy; pcwe = rdy; end
      1:  a2 = 2'b11;
      2:  begin a1 = 1; a2 = 2'b10; end
      3:  begin mreq = 1; ids = 1; end
      4:  begin rfwe = 1; mtorf = 1; end
      5:  begin mreq = 1; ids = 1; dmwe = rdy; end
      6:  begin a1 = 1; alu = funct_alu(fn); end
      7:  begin rfwe = 1; rfd = 1; end
      8:  begin a1 = 1; alu = 3'b110; pcsel = 2'b01; br = 1; end
      9:  begin a1 = 1; a2 = 2'b10; end
      10: rfwe = 1;
      11: begin pcsel = 2'b10; pcwe = 1; end
      default: ;
    endcase
    pcen = pcwe | (br & (zero ^ (op == OP_BNE)));
    if (!rstn) begin
      irwe = 0; pcwe = 0; pcen = 0; dmwe = 0; rfwe = 0;
    end
    return {mreq, mtorf, rfd, ids, a1, irwe, dmwe, pcwe, br, rfwe, pcen, pcsel, a2, alu, ill};
  endfunction

  int m_idx = 0;
  logic [31:0] m_cnt = 32'd0;
  logic m_ill = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_idx <= 0;
      m_cnt <= 32'd0;
      m_ill <= 1'b0;
    end else if (path_state(OPCODE, m_idx) != 12 &&
                 !((path_state(OPCODE, m_idx) inside {0, 3, 5}) && !MEM_RDY)) begin
      if (m_idx + 1 == path_len(OPCODE)) begin
        m_idx <= 0;
        m_cnt <= m_cnt + 32'd1;
      end else begin
        m_idx <= m_idx + 1;
        if (path_state(OPCODE, m_idx + 1) == 12) m_ill <= 1'b1;
      end
    end
  end

  logic [18:0] w_ctrl, w_ctrl4;
  assign w_ctrl  = {MEM_REQ, MtoRFSel, RFDSel, IDSel, ALUIn1Sel, IRWE, DMWE, PCWE, Branch, RFWE,
                    PCEn, PCSel, ALUIn2Sel, ALUSel, ILLEGAL};
  assign w_ctrl4 = {d4_MEM_REQ, d4_MtoRFSel, d4_RFDSel, d4_IDSel, d4_ALUIn1Sel, d4_IRWE, d4_DMWE,
                    d4_PCWE, d4_Branch, d4_RFWE, d4_PCEn, d4_PCSel, d4_ALUIn2Sel, d4_ALUSel,
                    d4_ILLEGAL};

  int cmp_st;
  logic [18:0] cmp_exp;
  always @(negedge CLK) begin
    if (chk_en) begin
      cmp_st  = path_state(OPCODE, m_idx);
      cmp_exp = exp_ctrl(cmp_st, MEM_RDY, ZERO, RST, OPCODE, FUNCT, m_ill);
      chk("state", STATE, cmp_st);
      chk("ctrl", w_ctrl, cmp_exp);
      chk("cnt", INSTR_CNT, m_cnt);
      chk("d4_state", d4_STATE, cmp_st);
      chk("d4_ctrl", w_ctrl4, cmp_exp);
      chk("d4_cnt", d4_INSTR_CNT, m_cnt & 32'hF);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
    ticks++;
  endtask

  task automatic do_branch(input logic [5:0] op, input logic z, input logic exp_pcen,
                           input string name);
    OPCODE = op;
    ZERO = z;
    tick();
    tick();
    chk({name, "_state"}, STATE, 8);
    chk({name, "_pcen"}, PCEn, exp_pcen);
    chk({name, "_alusel"}, ALUSel, 3'b110);
    tick();
  endtask

  int t0;
  int trap_cyc;
  int r;
  logic [5:0] ops[7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
  logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    #1;
    chk("rst_state", STATE, 0);
    chk("rst_mreq", MEM_REQ, 1);
    chk("rst_irwe", IRWE, 0);
    chk("rst_pcwe", PCWE, 0);
    chk("rst_pcen", PCEn, 0);
    chk("rst_cnt", INSTR_CNT, 0);
    RST = 1'b1;
    #1;
    chk("fetch_irwe", IRWE, 1);

    // R-type add
    tick(); chk("r_dec", STATE, 1);
    tick(); chk("r_exe", STATE, 6); chk("r_alusel", ALUSel, 3'b010);
    tick(); chk("r_wb", STATE, 7); chk("r_rfwe", RFWE, 1); chk("r_rfdsel", RFDSel, 1);
    tick(); chk("r_fetch", STATE, 0); chk("r_cnt", INSTR_CNT, 1);

    // LW with three wait cycles in MEMRD
    t0 = ticks;
    OPCODE = OP_LW;
    tick(); tick(); chk("lw_adr", STATE, 2);
    MEM_RDY = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("lw_rd_state", STATE, 3);
      chk("lw_rd_mreq", MEM_REQ, 1);
      chk("lw_rd_idsel", IDSel, 1);
      if (k == 3) MEM_RDY = 1'b1;
      tick();
    end
    chk("lw_wb", STATE, 4); chk("lw_mtorf", MtoRFSel, 1); chk("lw_rfwe", RFWE, 1);
    tick();
    chk("lw_len", ticks - t0, 8);
    chk("lw_cnt", INSTR_CNT, 2);

    do_branch(OP_BEQ, 1'b1, 1'b1, "beq_z1");
    do_branch(OP_BNE, 1'b1, 1'b0, "bne_z1");
    do_branch(OP_BNE, 1'b0, 1'b1, "bne_z0");
    chk("br_cnt", INSTR_CNT, 5);

    // illegal opcode
    OPCODE = 6'h3F;
    tick(); tick();
    chk("trap_state", STATE, 12);
    chk("trap_ill", ILLEGAL, 1);
    for (int k = 0; k < 10; k++) begin
      MEM_RDY = 1'($urandom_range(0, 1));
      #1;
      chk("trap_we", {IRWE, PCWE, PCEn, DMWE, RFWE, MEM_REQ}, 0);
      tick();
    end
    chk("trap_hold", STATE, 12);
    chk("trap_cnt", INSTR_CNT, 5);
    RST = 1'b0;
    #1;
    chk("trap_rst_ill", ILLEGAL, 0);
    chk("trap_rst_state", STATE, 0);
    tick();
    RST = 1'b1;
    MEM_RDY = 1'b1;

    // ADDI then SW abandoned by reset in MEMWR
    OPCODE = OP_ADDI;
    tick(); tick(); chk("addi_ex", STATE, 9);
    tick(); chk("addi_wb", STATE, 10); chk("addi_rfwe", RFWE, 1);
    tick(); chk("addi_cnt", INSTR_CNT, 1);
    OPCODE = OP_SW;
    tick(); tick(); tick();
    chk("sw_wr", STATE, 5);
    chk("sw_dmwe", DMWE, 1);
    RST = 1'b0;
    #1;
    chk("sw_rst_dmwe", DMWE, 0);
    chk("sw_rst_state", STATE, 0);
    chk("sw_rst_cnt", INSTR_CNT, 0);
    tick();
    RST = 1'b1;

    // counter wrap on the 4-bit instance
    OPCODE = OP_J;
    for (int k = 0; k < 16; k++) begin
      tick(); tick(); tick();
      if (k == 14) chk("wrap_15", d4_INSTR_CNT, 15);
    end
    chk("wrap_0", d4_INSTR_CNT, 0);
    chk("wrap_wide", INSTR_CNT, 16);

    // randomized instruction stream
    trap_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      if (path_state(OPCODE, m_idx) == 0) begin
        r = $urandom_range(0, 99);
        OPCODE = (r < 3) ? 6'($urandom) : ops[$urandom_range(0, 6)];
        FUNCT = ($urandom_range(0, 99) < 80) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      end
      MEM_RDY = ($urandom_range(0, 99) < 65);
      ZERO = 1'($urandom_range(0, 1));
      trap_cyc = (path_state(OPCODE, m_idx) == 12) ? trap_cyc + 1 : 0;
      if (!RST) RST = 1'b1;
      else if (trap_cyc > 5 || $urandom_range(0, 299) == 0) RST = 1'b0;
      tick();
    end

    RST = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
